// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, BITS_PER_CYCLE bits retired per CALC cycle.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic [4:0]      rdIn,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rdOut
);
  localparam int N = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0] op;
  logic neg_a, neg_b;
  logic [4:0] rd_q;
  logic [XLEN-1:0] opd;
  logic [2*XLEN-1:0] acc, acc_nx, prod;
  logic [XLEN:0] rr, t;
  logic ge;
  logic accept, sa, sb, a_neg, b_neg, div_zero, ovf, fast;
  logic [XLEN-1:0] a_mag, b_mag, fast_res, quo, rem, fix_res;
  assign accept = (state == IDLE || state == DONE) && start && !flush;
  assign sa = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign sb = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign a_neg = sa & srcA[XLEN-1];
  assign b_neg = sb & srcB[XLEN-1];
  assign a_mag = a_neg ? -srcA : srcA;
  assign b_mag = b_neg ? -srcB : srcB;
  assign div_zero = funct3[2] && srcB == '0;
  assign ovf = funct3[2] && !funct3[0] && srcA == {1'b1, {(XLEN-1){1'b0}}} && &srcB;
  assign fast = div_zero | ovf;
  assign fast_res = div_zero ? (funct3[1] ? srcA : '1) : (funct3[1] ? '0 : srcA);
  // acc holds {hi, lo}: product/multiplier for multiply, remainder/quotient for divide
  always_comb begin
    acc_nx = acc;
    rr = '0;
    t = '0;
    ge = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op[2]) begin
        rr = {acc_nx[2*XLEN-1:XLEN], acc_nx[XLEN-1]};
        ge = rr >= {1'b0, opd};
        rr = ge ? rr - {1'b0, opd} : rr;
        acc_nx = {rr[XLEN-1:0], acc_nx[XLEN-2:0], ge};
      end else begin
        t = {1'b0, acc_nx[2*XLEN-1:XLEN]} + (acc_nx[0] ? {1'b0, opd} : '0);
        acc_nx = {t, acc_nx[XLEN-1:1]};
      end
    end
  end
  assign prod = (neg_a ^ neg_b) ? -acc : acc;
  assign quo = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign fix_res = op[2] ? (op[1] ? rem : quo) : (op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = flush ? IDLE :
               accept ? (fast ? DONE : CALC) :
               state == CALC ? (cnt == LAST ? FIX : CALC) :
               state == FIX ? DONE : IDLE;
  end
  always_comb begin
    busy = state == CALC || state == FIX;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      op <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      rd_q <= '0;
      opd <= '0;
      acc <= '0;
      result <= '0;
      rdOut <= '0;
    end else begin
      cnt <= (state == CALC && state_nx == CALC) ? cnt + 1'b1 : '0;
      if (accept) begin
        op <= funct3;
        neg_a <= a_neg;
        neg_b <= b_neg;
        rd_q <= rdIn;
        opd <= funct3[2] ? b_mag : a_mag;
        acc <= {{XLEN{1'b0}}, funct3[2] ? a_mag : b_mag};
        if (fast) begin
          result <= fast_res;
          rdOut <= rdIn;
        end
      end else if (state == CALC) acc <= acc_nx;
      if (state == FIX && !flush) begin
        result <= fix_res;
        rdOut <= rd_q;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit at 1 and 4 bits per cycle.
module tb_muldiv_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, start, start4, flush;
  logic [2:0] funct3;
  logic [31:0] srcA, srcB;
  logic [4:0] rdIn;
  logic busy_1, done_1, busy_4, done_4;
  logic [31:0] result_1, result_4;
  logic [4:0] rd_1, rd_4;
  int pass_cnt = 0;
  int total = 0;

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .srcA(srcA), .srcB(srcB),
    .rdIn(rdIn), .flush(flush), .busy(busy_1), .done(done_1), .result(result_1), .rdOut(rd_1)
  );
  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .funct3(funct3), .srcA(srcA), .srcB(srcB),
    .rdIn(rdIn), .flush(flush), .busy(busy_4), .done(done_4), .result(result_4), .rdOut(rd_4)
  );

  // Cycle c is observed at the falling edge just before rising edge c.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       output int lat1, output int lat4, output int busy1,
                       output logic [31:0] r1, output logic [31:0] r4, output logic [4:0] t1);
    @(negedge clk);
    start = 1'b1; start4 = 1'b1; funct3 = f; srcA = a; srcB = b; rdIn = rd;
    lat1 = -1; lat4 = -1; busy1 = 0; r1 = 'x; r4 = 'x; t1 = 'x;
    for (int c = 1; c <= 60 && (lat1 < 0 || lat4 < 0); c++) begin
      @(negedge clk);
      if (c == 1) begin start = 1'b0; start4 = 1'b0; end
      if (busy_1) busy1++;
      if (done_1 && lat1 < 0) begin lat1 = c; r1 = result_1; t1 = rd_1; end
      if (done_4 && lat4 < 0) begin lat4 = c; r4 = result_4; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy_1 !== 1'b0) $display("FAIL reset busy actual=%b required=0", busy_1); else pass_cnt++;
    total++; if (done_1 !== 1'b0) $display("FAIL reset done actual=%b required=0", done_1); else pass_cnt++;
    total++; if (result_1 !== 32'h0) $display("FAIL reset result actual=%h required=0", result_1); else pass_cnt++;
    total++; if (rd_1 !== 5'd0) $display("FAIL reset rdOut actual=%0d required=0", rd_1); else pass_cnt++;
    total++; if (busy_4 !== 1'b0 || result_4 !== 32'h0) $display("FAIL reset u4 actual=%b/%h required=0/0", busy_4, result_4); else pass_cnt++;
    reset = 1'b1;
  endtask

  task automatic test_ops(input string nm, input int n, input int lat_a, input int lat_b, input int busy_req,
                          input logic [2:0] f [8], input logic [31:0] a [8], input logic [31:0] b [8],
                          input logic [31:0] e [8], input logic [4:0] rd);
    int l1, l4, bc;
    logic [31:0] r1, r4;
    logic [4:0] t1;
    for (int i = 0; i < n; i++) begin
      issue(f[i], a[i], b[i], rd, l1, l4, bc, r1, r4, t1);
      total++; if (l1 !== lat_a) $display("FAIL %s[%0d] latency actual=%0d required=%0d", nm, i, l1, lat_a); else pass_cnt++;
      total++; if (bc !== busy_req) $display("FAIL %s[%0d] busy_cycles actual=%0d required=%0d", nm, i, bc, busy_req); else pass_cnt++;
      total++; if (r1 !== e[i]) $display("FAIL %s[%0d] result actual=%h required=%h", nm, i, r1, e[i]); else pass_cnt++;
      total++; if (t1 !== rd) $display("FAIL %s[%0d] rdOut actual=%0d required=%0d", nm, i, t1, rd); else pass_cnt++;
      total++; if (l4 !== lat_b) $display("FAIL %s[%0d] latency_bpc4 actual=%0d required=%0d", nm, i, l4, lat_b); else pass_cnt++;
      total++; if (r4 !== e[i]) $display("FAIL %s[%0d] result_bpc4 actual=%h required=%h", nm, i, r4, e[i]); else pass_cnt++;
    end
  endtask

  task automatic test_mul();
    logic [2:0] f [8] = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd0, 3'd0};
    logic [31:0] a [8] = '{32'hFFFFFFF9, 32'h7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0};
    logic [31:0] b [8] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0};
    logic [31:0] e [8] = '{32'h15, 32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 0, 0};
    test_ops("mul", 5, 34, 10, 33, f, a, b, e, 5'd5);
  endtask

  task automatic test_div();
    logic [2:0] f [8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd0, 3'd0};
    logic [31:0] a [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7, 0, 0};
    logic [31:0] b [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 0, 0};
    logic [31:0] e [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1, 0, 0};
    test_ops("div", 6, 34, 10, 33, f, a, b, e, 5'd6);
  endtask

  task automatic test_special();
    logic [2:0] f [8] = '{3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd0, 3'd0, 3'd0};
    logic [31:0] a [8] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5, 0, 0, 0};
    logic [31:0] b [8] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 0, 0, 0};
    logic [31:0] e [8] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 0, 0, 0};
    test_ops("special", 5, 1, 1, 0, f, a, b, e, 5'd9);
  endtask

  task automatic test_flush();
    int lat = -1;
    logic [31:0] r = 'x;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; srcA = 32'd100; srcB = 32'd7; rdIn = 5'd12;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 10) begin
        total++; if (busy_1 !== 1'b1) $display("FAIL flush busy_before actual=%b required=1", busy_1); else pass_cnt++;
      end
      if (c == 11) begin
        total++; if (busy_1 !== 1'b0) $display("FAIL flush busy_after actual=%b required=0", busy_1); else pass_cnt++;
        total++; if (rd_1 !== 5'd9) $display("FAIL flush rdOut_kept actual=%0d required=9", rd_1); else pass_cnt++;
        total++; if (result_1 !== 32'hFFFFFFFF) $display("FAIL flush result_kept actual=%h required=ffffffff", result_1); else pass_cnt++;
      end
      if (done_1 && lat < 0) begin lat = c; r = result_1; end
      if (c == 1) start = 1'b0;
      if (c == 10) flush = 1'b1;
      if (c == 11) begin flush = 1'b0; start = 1'b1; funct3 = 3'd0; srcA = 32'd6; srcB = 32'd7; rdIn = 5'd13; end
      if (c == 12) start = 1'b0;
    end
    total++; if (lat !== 45) $display("FAIL flush mul_latency actual=%0d required=45", lat); else pass_cnt++;
    total++; if (r !== 32'd42) $display("FAIL flush mul_result actual=%h required=%h", r, 32'd42); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int la = -1;
    int lb = -1;
    logic [31:0] ra = 'x;
    logic [31:0] rb = 'x;
    logic [4:0] ta = 'x;
    logic [4:0] tb = 'x;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; srcA = 32'd7; srcB = 32'd3; rdIn = 5'd3;
    for (int c = 1; c <= 75; c++) begin
      @(negedge clk);
      if (done_1 && la < 0) begin la = c; ra = result_1; ta = rd_1; end
      else if (done_1 && lb < 0) begin lb = c; rb = result_1; tb = rd_1; end
      if (c == 35) begin
        total++; if (busy_1 !== 1'b1) $display("FAIL b2b second_busy actual=%b required=1", busy_1); else pass_cnt++;
      end
      if (c == 1) begin funct3 = 3'd5; srcA = 32'd100; srcB = 32'd7; rdIn = 5'd4; end
      if (c == 35) start = 1'b0;
    end
    total++; if (la !== 34) $display("FAIL b2b first_latency actual=%0d required=34", la); else pass_cnt++;
    total++; if (ra !== 32'd21 || ta !== 5'd3) $display("FAIL b2b first actual=%h/%0d required=15/3", ra, ta); else pass_cnt++;
    total++; if (lb !== 68) $display("FAIL b2b second_latency actual=%0d required=68", lb); else pass_cnt++;
    total++; if (rb !== 32'd14 || tb !== 5'd4) $display("FAIL b2b second actual=%h/%0d required=e/4", rb, tb); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start = 1'b1; start4 = 1'b1; funct3 = 3'd0; srcA = 32'd5; srcB = 32'd5; rdIn = 5'd7;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 5) begin
        total++; if (busy_1 !== 1'b1) $display("FAIL midreset busy_before actual=%b required=1", busy_1); else pass_cnt++;
      end
      if (c == 6) begin
        total++; if (busy_1 !== 1'b0 || done_1 !== 1'b0) $display("FAIL midreset busy/done actual=%b/%b required=0/0", busy_1, done_1); else pass_cnt++;
        total++; if (result_1 !== 32'h0 || rd_1 !== 5'd0) $display("FAIL midreset result/rdOut actual=%h/%0d required=0/0", result_1, rd_1); else pass_cnt++;
        total++; if (busy_4 !== 1'b0 || result_4 !== 32'h0 || rd_4 !== 5'd0) $display("FAIL midreset u4 actual=%b/%h/%0d required=0/0/0", busy_4, result_4, rd_4); else pass_cnt++;
      end
      if (c == 1) begin start = 1'b0; start4 = 1'b0; end
      if (c == 5) reset = 1'b0;
    end
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; start4 = 1'b0; flush = 1'b0;
    funct3 = 3'd0; srcA = 32'h0; srcB = 32'h0; rdIn = 5'd0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the pipelined core. It replaces the fixed-latency multiplier behind the hazard unit's `MulBusy` input. It accepts one operation from the Execute stage and computes it over a configurable number of iterations. It returns the result with its destination register tag and supports abort on pipeline flush.

## Interface
- `XLEN`, 32, operand and result width; must be even, at least 8.
- `BITS_PER_CYCLE`, 1, bits retired per iteration (1, 2 or 4); must divide `XLEN`; N = `XLEN`/`BITS_PER_CYCLE`.
- `clk` input 1: single clock. All state changes on its rising edge.
- `reset` input 1: synchronous, active-low. Sampled on the rising edge of `clk`.
- `start` input 1: request a new operation. Accepted only when `busy`=0.
- `funct3` input 3: RV32M operation select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `srcA`, `srcB` input `XLEN`: rs1 and rs2 operands.
- `rdIn` input 5: destination register tag.
- `flush` input 1: abort the in-flight operation.
- `busy` output 1: high while an accepted operation is iterating. Drives the hazard unit's `MulBusy`.
- `done` output 1: single-cycle pulse marking `result` and `rdOut` as valid.
- `result` output `XLEN`: operation result. Holds its value until the next `done`.
- `rdOut` output 5: tag captured at accept. Holds its value until the next `done`.

## Operation
- FSM states:
  - IDLE
  - CALC: iteration counter 0..N-1
  - FIX: sign correction and result selection
  - DONE
- IDLE/DONE with `start`=1 and `flush`=0: latch the operands, `funct3` and `rdIn`, then go to CALC.
  - DONE with `start`=0: return to IDLE.
  - Back-to-back issue from DONE is legal.
- Fast path at accept, going straight to DONE with no CALC/FIX:
  - Divide by zero (`srcB`=0, funct3 1xx): quotient = all ones; remainder = `srcA`.
  - Signed overflow (DIV/REM, `srcA`=most-negative, `srcB`=all ones): quotient = `srcA`; remainder = 0.
- Multiply:
  - Operands are converted to magnitudes according to the signedness of `funct3` (MULHSU: A signed, B unsigned).
  - A 2·`XLEN` product is formed by shift-add, retiring `BITS_PER_CYCLE` multiplier bits per CALC cycle.
  - In FIX, the product is negated if the operand signs differ.
  - MUL returns the low `XLEN` bits; MULH/MULHSU/MULHU return the high `XLEN` bits.
- Divide:
  - Restoring division on magnitudes, retiring `BITS_PER_CYCLE` quotient bits per CALC cycle.
  - In FIX:
    - The quotient is negated if the signs differ (signed ops only).
    - The remainder takes the sign of the dividend.
- `flush`=1 in any state: next state is IDLE. No `done` is produced, and `result` and `rdOut` are unchanged.
  - `flush` takes priority over a simultaneous `start`.
- `start` while `busy`=1 is ignored. The hazard unit is responsible for stalling the pipeline.
- Reset state: IDLE. `busy`=0, `done`=0, `result`=0, `rdOut`=0, counter=0. This applies mid-operation as well.

## Timing
- Cycle numbering: cycle 0 is the rising edge at which `start` is sampled.
- Normal path:
  - `busy`=1 during cycles 1..N+1 (CALC occupies cycles 1..N, FIX occupies cycle N+1).
  - `done`=1 in cycle N+2, with `busy`=0.
  - Latency is N+2 cycles. With `XLEN`=32 and `BITS_PER_CYCLE`=1 this is 34.
- Fast path:
  - `done`=1 in cycle 1.
  - `busy` stays 0.
- A `start` sampled in the DONE cycle begins a new operation. Its CALC starts in the next cycle.
- `flush` sampled at cycle k: `busy`=0 at cycle k+1, and a new `start` is accepted at cycle k+1.
- Outputs are registered. There is no combinational path from the inputs to `busy`, `done` or `result`.

## Test plan
- MUL -7 × -3, and MUL 7 × -3 (0xFFFFFFF9 × 0xFFFFFFFD, 0x00000007 × 0xFFFFFFFD), `rdIn`=5:
  - `done` at cycle 34, `rdOut`=5.
  - `result` = 0x00000015 and 0xFFFFFFEB respectively.
  - `busy` high during cycles 1–33.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Division:
  - DIV -7/2 → 0xFFFFFFFD.
  - REM -7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
  - Each completes at cycle 34.
- Special cases (each must give `done` at cycle 1 with `busy` never asserted):
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- Abort and back-to-back:
  - `flush` at cycle 10 of a DIV: no `done`, `busy`=0 at cycle 11, and a MUL started at cycle 11 completes at cycle 45.
  - A `start` held during DONE is accepted.
  - A `start` while busy is ignored.
  - `reset`=0 mid-CALC gives all outputs 0 on the next cycle.
- `BITS_PER_CYCLE`=4 rerun of the first three scenarios: identical results, `done` at cycle 10.
